// File: rtl/nco_freq_meter_if.sv
// Sample stream in, period/control-word measurement out.
interface nco_freq_meter_if;
  logic [7:0]  amplitude;
  logic        valid;
  logic [24:0] period_avg;
  logic [15:0] control_est;
  logic        locked;
  logic        no_signal;

  modport master (
    output amplitude,
    input  valid, period_avg, control_est, locked, no_signal
  );

  modport slave (
    input  amplitude,
    output valid, period_avg, control_est, locked, no_signal
  );
endinterface

// File: rtl/nco_freq_meter.sv
// Recovers period and NCO control word from a midscale-biased sample stream
// using hysteretic rising-crossing detection averaged over 2^AVG periods.
module nco_freq_meter #(
  parameter int unsigned S       = 8,
  parameter int unsigned AVG     = 2,
  parameter int unsigned HYST    = 16,
  parameter int unsigned TIMEOUT = 33554431
) (
  input  logic              clk,
  input  logic              reset,
  nco_freq_meter_if.slave   bus
);

  localparam int unsigned AW = 25 + AVG;
  localparam int unsigned NW = AVG + 1;
  localparam logic [7:0]    HI       = 8'(128 + HYST);
  localparam logic [7:0]    LO       = 8'(128 - HYST);
  localparam logic [NW-1:0] NLAST    = NW'((1 << AVG) - 1);
  localparam logic [24:0]   CNT_LAST = 25'(TIMEOUT - 1);

  typedef enum logic {SEARCH, MEASURE} state_t;
  state_t state, state_next;

  logic [7:0]    s_q;
  logic          armed, lvl;
  logic [24:0]   cnt;
  logic [AW-1:0] acc;
  logic [NW-1:0] ncyc;
  logic          has_est;

  logic          rise, timeout, win_done;
  logic [AW-1:0] acc_final, quo;
  logic [15:0]   est;

  assign rise = armed & ~lvl & (s_q >= HI);

  always_ff @(posedge clk) begin
    if (reset) state <= SEARCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SEARCH:  if (rise) state_next = MEASURE;
      MEASURE: if (!rise && cnt == CNT_LAST) state_next = SEARCH;
      default: state_next = SEARCH;
    endcase
  end

  always_comb begin
    timeout  = 1'b0;
    win_done = 1'b0;
    if (state == MEASURE) begin
      timeout  = !rise && (cnt == CNT_LAST);
      win_done = rise && (ncyc == NLAST);
    end
  end

  // The closing period (cnt+1) is folded into the sum before scaling.
  always_comb begin
    acc_final = acc + AW'(cnt) + AW'(1);
    quo       = acc_final >> (AVG + S);
    est       = '0;
    if (quo != '0) begin
      if ((quo - AW'(1)) > AW'(16'hFFFF)) est = '1;
      else                                est = 16'(quo - AW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q             <= 8'h80;
      armed           <= 1'b0;
      lvl             <= 1'b0;
      cnt             <= '0;
      acc             <= '0;
      ncyc            <= '0;
      has_est         <= 1'b0;
      bus.valid       <= 1'b0;
      bus.period_avg  <= '0;
      bus.control_est <= '0;
      bus.locked      <= 1'b0;
      bus.no_signal   <= 1'b1;
    end else begin
      s_q       <= bus.amplitude;
      bus.valid <= 1'b0;
      if (s_q < LO) begin
        lvl   <= 1'b0;
        armed <= 1'b1;
      end else if (s_q >= HI) begin
        lvl <= 1'b1;
      end

      if (state == SEARCH) begin
        cnt  <= '0;
        acc  <= '0;
        ncyc <= '0;
      end else if (rise) begin
        cnt <= '0;
        if (win_done) begin
          acc             <= '0;
          ncyc            <= '0;
          bus.valid       <= 1'b1;
          bus.period_avg  <= 25'(acc_final >> AVG);
          bus.control_est <= est;
          bus.locked      <= has_est && (est == bus.control_est);
          has_est         <= 1'b1;
          bus.no_signal   <= 1'b0;
        end else begin
          acc  <= acc_final;
          ncyc <= ncyc + NW'(1);
        end
      end else if (timeout) begin
        // Disarm so a signal returning high is not mistaken for an edge.
        cnt           <= '0;
        acc           <= '0;
        ncyc          <= '0;
        armed         <= 1'b0;
        lvl           <= 1'b0;
        has_est       <= 1'b0;
        bus.no_signal <= 1'b1;
        bus.locked    <= 1'b0;
      end else begin
        cnt <= cnt + 25'd1;
      end
    end
  end

endmodule

// File: tb/tb_nco_freq_meter.sv
// Scoreboard bench for nco_freq_meter: timestamp-based crossing model, randomized waveforms.
module tb_nco_freq_meter;
  localparam int S       = 8;
  localparam int AVG     = 2;
  localparam int HYST    = 16;
  localparam int TIMEOUT = 4096;
  localparam int NAVG    = 1 << AVG;
  localparam int HI      = 128 + HYST;
  localparam int LO      = 128 - HYST;

  logic clk = 1'b0;
  logic reset = 1'b1;
  nco_freq_meter_if bus();

  nco_freq_meter #(.S(S), .AVG(AVG), .HYST(HYST), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int pa; int ce; bit lk; int due; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 0;
  int n_valid  = 0;
  int last_pa, last_ce;
  bit last_lk;

  // expected held outputs, indexed by the cycle they become visible
  int p_pa[4];
  int p_ce[4];
  bit p_ns[4];
  bit p_lk[4];

  // reference model state
  bit m_meas, m_armed, m_lvl, m_has_est, m_ns, m_lk;
  int m_last, m_pa, m_ce;
  int m_per[$];
  int ph = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic model_reset();
    m_meas = 0; m_armed = 0; m_lvl = 0; m_has_est = 0;
    m_ns = 1; m_lk = 0; m_pa = 0; m_ce = 0; m_last = 0;
    m_per.delete();
  endtask

  task automatic set_slot(input int c);
    p_pa[c % 4] = m_pa; p_ce[c % 4] = m_ce;
    p_ns[c % 4] = m_ns; p_lk[c % 4] = m_lk;
  endtask

  task automatic model_sample(input int v, input int k);
    bit hi, rise;
    int sum, q, est;
    exp_t e;
    hi   = (v >= HI);
    rise = m_armed && !m_lvl && hi;
    if (v < LO) begin m_lvl = 0; m_armed = 1; end
    else if (hi) m_lvl = 1;
    if (!m_meas) begin
      if (rise) begin m_meas = 1; m_last = k; m_per.delete(); end
    end else if (rise) begin
      m_per.push_back(k - m_last);
      m_last = k;
      if (m_per.size() == NAVG) begin
        sum = 0;
        foreach (m_per[i]) sum += m_per[i];
        q   = sum >> (AVG + S);
        est = (q == 0) ? 0 : ((q - 1 > 65535) ? 65535 : q - 1);
        e.pa = sum >> AVG; e.ce = est; e.lk = m_has_est && (est == m_ce); e.due = k + 2;
        sb.push_back(e);
        m_pa = e.pa; m_ce = est; m_lk = e.lk; m_ns = 0; m_has_est = 1;
        m_per.delete();
      end
    end else if (k - m_last == TIMEOUT) begin
      m_meas = 0; m_armed = 0; m_lvl = 0; m_has_est = 0;
      m_ns = 1; m_lk = 0;
      m_per.delete();
    end
    set_slot(k + 2);
  endtask

  task automatic step(input int v, input bit rst);
    int k;
    @(posedge clk); #1;
    k = cyc;
    reset = rst;
    bus.amplitude = 8'(v);
    if (rst) begin
      model_reset();
      set_slot(k + 1);
      set_slot(k + 2);
      while (sb.size() > 0 && sb[$].due >= k + 1) void'(sb.pop_back());
    end else begin
      model_sample(v, k);
    end
  endtask

  function automatic int tri_wave(input int p, input int per, input int amp);
    int half;
    half = per / 2;
    if (p < half) return 128 - amp + (2 * amp * p) / half;
    return 128 + amp - (2 * amp * (p - half)) / half;
  endfunction

  task automatic run(input int per, input int amp, input int n, input int noise);
    int v;
    for (int i = 0; i < n; i++) begin
      v = tri_wave(ph % per, per, amp);
      if (noise > 0) v = v + int'($urandom_range(2 * noise)) - noise;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      step(v, 0);
      ph = (ph + 1) % per;
    end
  endtask

  task automatic hold(input int v, input int n);
    for (int i = 0; i < n; i++) step(v, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(bus.valid == 1'b0, {tag, "_valid"}, $sformatf("got %0d want 0", bus.valid));
    check(bus.period_avg == 25'd0, {tag, "_period"}, $sformatf("got %0d want 0", bus.period_avg));
    check(bus.control_est == 16'd0, {tag, "_est"}, $sformatf("got %0d want 0", bus.control_est));
    check(bus.locked == 1'b0, {tag, "_locked"}, $sformatf("got %0d want 0", bus.locked));
    check(bus.no_signal == 1'b1, {tag, "_no_signal"}, $sformatf("got %0d want 1", bus.no_signal));
  endtask

  task automatic check_last(input string tag, input int pa, input int ce, input bit lk);
    check(last_pa == pa && last_ce == ce && last_lk == lk, tag,
          $sformatf("got period=%0d est=%0d locked=%0d want period=%0d est=%0d locked=%0d",
                    last_pa, last_ce, last_lk, pa, ce, lk));
  endtask

  always @(negedge clk) begin
    int s;
    exp_t e;
    if (mon_en) begin
      s = cyc % 4;
      check(bus.no_signal == p_ns[s] && bus.locked == p_lk[s] &&
            int'(bus.period_avg) == p_pa[s] && int'(bus.control_est) == p_ce[s], "status",
            $sformatf("cyc %0d got ns=%0d lk=%0d pa=%0d ce=%0d want ns=%0d lk=%0d pa=%0d ce=%0d",
                      cyc, bus.no_signal, bus.locked, bus.period_avg, bus.control_est,
                      p_ns[s], p_lk[s], p_pa[s], p_ce[s]));
      if (bus.valid) begin
        n_valid++;
        last_pa = int'(bus.period_avg);
        last_ce = int'(bus.control_est);
        last_lk = bus.locked;
        check(sb.size() != 0, "valid_unexpected", $sformatf("valid at cyc %0d, want none", cyc));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check(e.due == cyc && e.pa == last_pa && e.ce == last_ce && e.lk == last_lk, "valid_result",
                $sformatf("got cyc=%0d pa=%0d ce=%0d lk=%0d want cyc=%0d pa=%0d ce=%0d lk=%0d",
                          cyc, last_pa, last_ce, last_lk, e.due, e.pa, e.ce, e.lk));
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        check(bus.valid, "valid_missing", $sformatf("got no valid at cyc %0d want one due %0d", cyc, e.due));
      end
    end
  end

  initial begin
    int nv0, per, amp;
    bus.amplitude = 8'h80;
    model_reset();
    for (int i = 0; i < 4; i++) set_slot(i);
    repeat (3) step(8'h80, 1);
    mon_en = 1;
    step(8'h80, 0);
    check_reset_outputs("reset");

    // control=3 -> period 1024
    ph = 0;
    run(1024, 100, 4096 * 3 + 600, 0);
    check_last("ctl3", 1024, 3, 1);
    check(bus.no_signal == 1'b0, "ctl3_no_signal", $sformatf("got %0d want 0", bus.no_signal));

    // switch to control=7 -> period 2048
    ph = 0;
    run(2048, 100, 8192 * 3 + 1200, 0);
    check_last("ctl7", 2048, 7, 1);

    // signal parked at midscale -> timeout, last result retained
    hold(8'h80, 4200);
    check(bus.no_signal == 1'b1 && bus.locked == 1'b0, "timeout_status",
          $sformatf("got ns=%0d lk=%0d want ns=1 lk=0", bus.no_signal, bus.locked));
    check(bus.period_avg == 25'd2048 && bus.control_est == 16'd7, "timeout_hold",
          $sformatf("got pa=%0d ce=%0d want pa=2048 ce=7", bus.period_avg, bus.control_est));

    // control=0 and a faster-than-NCO 128-clk period
    ph = 0;
    run(256, 100, 1024 * 3 + 400, 0);
    check_last("ctl0", 256, 0, 1);
    ph = 0;
    run(128, 100, 512 * 4 + 200, 0);
    check_last("p128_sat", 128, 0, 1);

    // toggling inside the hysteresis band never produces a crossing
    step(8'h80, 1);
    step(8'h80, 0);
    check_reset_outputs("reset2");
    nv0 = n_valid;
    for (int i = 0; i < 10000; i++) step((i % 2) ? 8'h86 : 8'h7A, 0);
    check(n_valid == nv0 && bus.no_signal == 1'b1, "band_toggle",
          $sformatf("got valids=%0d ns=%0d want valids=0 ns=1", n_valid - nv0, bus.no_signal));

    // reset in the middle of a measurement window
    ph = 0;
    run(256, 100, 1700, 0);
    step(8'h80, 1);
    step(8'h80, 0);
    check_reset_outputs("reset_mid");
    nv0 = n_valid;
    ph = 0;
    run(256, 100, 1024 + 50, 0);
    check(n_valid == nv0, "post_reset_early", $sformatf("got %0d valids want 0", n_valid - nv0));
    run(256, 100, 200, 0);
    check(n_valid == nv0 + 1 && last_pa == 256, "post_reset_first",
          $sformatf("got valids=%0d pa=%0d want valids=1 pa=256", n_valid - nv0, last_pa));

    // randomized waveforms with noise and short midscale gaps
    for (int seg = 0; seg < 6; seg++) begin
      per = int'($urandom_range(700, 128));
      amp = int'($urandom_range(110, 40));
      ph  = int'($urandom_range(per - 1, 0));
      run(per, amp, per * NAVG * 2 + int'($urandom_range(per, 0)), 3);
      if ($urandom_range(1, 0) == 1) hold(8'h80, int'($urandom_range(300, 0)));
    end

    hold(8'h80, 5);
    check(sb.size() == 0, "scoreboard_drain", $sformatf("got %0d pending want 0", sb.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/nco_freq_meter.md
Name: nco_freq_meter

Overview:
- Receive-side counterpart of the NCO: takes the 8-bit sinusoid sample stream and recovers its period and the NCO frequency control word that produced it.
- Detects rising midscale (0x80) crossings with hysteresis, averages the crossing-to-crossing period over 2^AVG cycles, and reports period, estimated control word, lock and loss-of-signal status.
- Used for closed-loop self-test of the NCO, or for measuring any external midscale-biased waveform.

Parameters:
- S, 8, log2 samples per NCO period; the estimate divides the period by 2^S.
- AVG, 2, log2 number of periods averaged per result (0..4).
- HYST, 16, hysteresis half-width in LSBs around 0x80 (1..127).
- TIMEOUT, 33554431, clocks without a rising crossing before loss of signal (<= 2^25-1).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- amplitude  input  8  sample stream, unsigned, midscale 0x80, one sample per clk.
- valid  output  1  one-cycle pulse when period_avg/control_est update.
- period_avg  output  25  averaged period in clk cycles.
- control_est  output  16  estimated control word.
- locked  output  1  two consecutive equal estimates.
- no_signal  output  1  no measurement yet, or timeout.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: valid=0, period_avg=0, control_est=0, locked=0, no_signal=1. Internal state after reset: FSM=SEARCH, sample reg=0x80, armed=0, lvl=0, cnt=0, acc=0, ncyc=0.
- Input register: amplitude is registered into s_q every clk. All comparisons use s_q.
- Thresholds: HI=0x80+HYST, LO=0x80-HYST. Both are compared unsigned.
- Hysteresis level:
  - s_q < LO: lvl<=0, armed<=1.
  - s_q >= HI: lvl<=1.
  - Otherwise lvl holds.
- rise = armed & ~lvl & (s_q >= HI). rise is asserted for exactly one cycle per crossing. Samples inside [LO,HI) never produce rise.
- The armed flag prevents a false edge when the signal starts high after reset or after a timeout.
- FSM SEARCH: cnt is held at 0. On rise: go to MEASURE, cnt<=0, acc<=0, ncyc<=0.
- FSM MEASURE, per cycle:
  - No rise: cnt<=cnt+1.
  - On rise: acc<=acc+cnt+1, cnt<=0, ncyc<=ncyc+1.
  - A rise that makes ncyc reach 2^AVG starts output processing and sets ncyc<=0, acc<=0.
- Output processing: the full sum acc_final = acc+cnt+1, 25+AVG bits, is used.
  - Next cycle: valid=1.
  - period_avg = acc_final>>AVG.
  - control_est = (acc_final>>(AVG+S)) - 1. Underflow saturates to 0; values above 0xFFFF saturate to 0xFFFF.
  - no_signal<=0.
- locked: on each valid, locked<=1 if the new control_est equals the previous valid's control_est, else locked<=0. The first valid after SEARCH always gives locked=0.
- Timeout: in MEASURE, if cnt reaches TIMEOUT-1 with no rise:
  - FSM goes to SEARCH; armed<=0, lvl<=0, acc/ncyc/cnt cleared.
  - no_signal<=1, locked<=0, no valid.
  - period_avg and control_est hold their last values.
- Simultaneous events: a rise in the same cycle cnt reaches TIMEOUT-1 counts as a rise; no timeout occurs.
- Reset mid-measurement: all state returns to reset values on the next edge, and no valid is emitted for the partial window.
- Latency: valid rises 2 clks after the amplitude sample that crosses HI (1 clk input register + 1 clk output register).
- Arithmetic: cnt is 25 bits. acc is 25+AVG bits and cannot overflow because TIMEOUT < 2^25.
- NCO relation: period = (control+1)*2^S clocks, so an ideal NCO input yields control_est == control exactly.

Test Plan:
- NCO control=3, default params: valid every 4096 clks, period_avg=1024, control_est=3; first valid locked=0, second valid locked=1, no_signal=0.
- NCO control=0: period_avg=256, control_est=0. Force a 128-clk period: control_est saturates to 0, not 0xFFFF.
- After lock at control=3, switch NCO to control=7: the next valid after the partial window gives locked=0. Settled values are period_avg=2048, control_est=7, with locked=1 on the following valid.
- TIMEOUT=4096: lock on control=3, then hold amplitude=0x80. No further valid; no_signal=1 and locked=0 exactly 4096 clks after the last rise; the old period_avg is retained.
- Toggle amplitude 0x7A/0x86 every clk for 10000 clks after reset: no rise, FSM stays in SEARCH, valid never asserted, no_signal=1.
- Assert reset for 1 clk midway through a MEASURE window: outputs return to their reset values and no valid is emitted for that window. The first valid after reset appears only after 2^AVG complete periods following the first post-reset rise.
